// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - six-digit seven-segment scan driver with blanking, PWM, frame latching and blink
module seg_scan_mux #(
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_FRAMES = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sec_u,
  input  logic [7:0] sec_t,
  input  logic [7:0] min_u,
  input  logic [7:0] min_t,
  input  logic [7:0] hrs_u,
  input  logic [7:0] hrs_t,
  input  logic [3:0] brightness,
  input  logic [5:0] blink_mask,
  output logic [7:0] seg,
  output logic [5:0] an,
  output logic       frame_start
);

  localparam int SW = $clog2(SLOT_CYCLES);
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  logic [SW-1:0]   slot_cnt_q, slot_cnt_d;
  logic [2:0]      digit_q, digit_d;
  logic [3:0]      pwm_cnt_q, pwm_cnt_d;
  logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
  logic            blink_phase_q, blink_phase_d;
  logic [5:0][7:0] shadow_pat_q, shadow_pat_d;
  logic [5:0]      shadow_mask_q, shadow_mask_d;
  logic [3:0]      shadow_bright_q, shadow_bright_d;
  logic [7:0]      seg_q, seg_d;
  logic [5:0]      an_q, an_d;
  logic            frame_start_q, frame_start_d;

  logic       slot_last;
  logic       capture;
  logic       enable;
  logic [5:0] digit_onehot;
  logic [7:0] cur_pat;

  always_comb begin
    slot_cnt_d      = slot_cnt_q;
    digit_d         = digit_q;
    pwm_cnt_d       = pwm_cnt_q;
    frame_cnt_d     = frame_cnt_q;
    blink_phase_d   = blink_phase_q;
    shadow_pat_d    = shadow_pat_q;
    shadow_mask_d   = shadow_mask_q;
    shadow_bright_d = shadow_bright_q;
    cur_pat         = 8'hFF;

    slot_last = (slot_cnt_q == SW'(SLOT_CYCLES - 1));
    capture   = (digit_q == 3'd0) && (slot_cnt_q == '0);

    slot_cnt_d = slot_last ? '0 : slot_cnt_q + 1'b1;
    if (slot_last) begin
      digit_d = (digit_q == 3'd5) ? 3'd0 : digit_q + 3'd1;
    end
    pwm_cnt_d = (pwm_cnt_q == 4'd14) ? 4'd0 : pwm_cnt_q + 4'd1;

    // Phase toggles on the same wrap that starts the next frame, so it lands together with the capture.
    if (slot_last && digit_q == 3'd5) begin
      if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end

    // Capture values are forwarded so the frame's first slot already shows the new patterns.
    if (capture) begin
      shadow_pat_d    = {hrs_t, hrs_u, min_t, min_u, sec_t, sec_u};
      shadow_mask_d   = blink_mask;
      shadow_bright_d = brightness;
    end

    case (digit_q)
      3'd0:    cur_pat = shadow_pat_d[0];
      3'd1:    cur_pat = shadow_pat_d[1];
      3'd2:    cur_pat = shadow_pat_d[2];
      3'd3:    cur_pat = shadow_pat_d[3];
      3'd4:    cur_pat = shadow_pat_d[4];
      3'd5:    cur_pat = shadow_pat_d[5];
      default: cur_pat = 8'hFF;
    endcase

    digit_onehot = 6'b000001 << digit_q;
    enable = (slot_cnt_q >= SW'(BLANK_CYCLES))
          && ((pwm_cnt_q < shadow_bright_d) || (shadow_bright_d == 4'd15))
          && !(blink_phase_q && |(shadow_mask_d & digit_onehot));

    seg_d         = cur_pat;
    an_d          = enable ? ~digit_onehot : 6'h3F;
    frame_start_d = capture;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_q      <= '0;
      digit_q         <= 3'd0;
      pwm_cnt_q       <= 4'd0;
      frame_cnt_q     <= '0;
      blink_phase_q   <= 1'b0;
      shadow_pat_q    <= {6{8'hFF}};
      shadow_mask_q   <= 6'd0;
      shadow_bright_q <= 4'd0;
      seg_q           <= 8'hFF;
      an_q            <= 6'h3F;
      frame_start_q   <= 1'b0;
    end else begin
      slot_cnt_q      <= slot_cnt_d;
      digit_q         <= digit_d;
      pwm_cnt_q       <= pwm_cnt_d;
      frame_cnt_q     <= frame_cnt_d;
      blink_phase_q   <= blink_phase_d;
      shadow_pat_q    <= shadow_pat_d;
      shadow_mask_q   <= shadow_mask_d;
      shadow_bright_q <= shadow_bright_d;
      seg_q           <= seg_d;
      an_q            <= an_d;
      frame_start_q   <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - scoreboard bench for seg_scan_mux
module tb_seg_scan_mux;

  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int BLINK = 2;
  localparam int FRAME = 6 * SLOT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pat_in [6];
  logic [3:0] brightness = 4'd15;
  logic [5:0] blink_mask = 6'd0;
  logic [7:0] seg;
  logic [5:0] an;
  logic       frame_start;

  always #5 clk = ~clk;

  seg_scan_mux #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK), .BLINK_FRAMES(BLINK)) dut (
    .clk(clk), .rst(rst),
    .sec_u(pat_in[0]), .sec_t(pat_in[1]), .min_u(pat_in[2]),
    .min_t(pat_in[3]), .hrs_u(pat_in[4]), .hrs_t(pat_in[5]),
    .brightness(brightness), .blink_mask(blink_mask),
    .seg(seg), .an(an), .frame_start(frame_start)
  );

  typedef struct {
    logic [5:0] an;
    logic [7:0] seg;
    logic       fs;
    logic       chk_seg;
    int         pos;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Expected outputs derive from the position t within the run since reset release.
  int         t = 0;
  logic [7:0] sh_pat [6];
  int         sh_br;
  logic [5:0] sh_mask;

  task automatic push_expect();
    exp_t       e;
    int         slot, dg, phase;
    logic       lit;
    logic [5:0] oh;
    if (rst) begin
      e.an = 6'h3F; e.seg = 8'hFF; e.fs = 1'b0; e.chk_seg = 1'b1; e.pos = -1;
      t = 0;
    end else begin
      if (t % FRAME == 0) begin
        for (int i = 0; i < 6; i++) sh_pat[i] = pat_in[i];
        sh_br   = int'(brightness);
        sh_mask = blink_mask;
      end
      slot  = t % SLOT;
      dg    = (t / SLOT) % 6;
      phase = (t / (FRAME * BLINK)) % 2;
      oh    = 6'b000001 << dg;
      lit   = (slot >= BLANK) && (((t % 15) < sh_br) || sh_br == 15)
              && !(phase == 1 && (sh_mask & oh) != 6'd0);
      e.an      = lit ? ~oh : 6'h3F;
      e.seg     = sh_pat[dg];
      e.fs      = (t % FRAME == 0);
      e.chk_seg = (t % FRAME != 0);
      e.pos     = t;
      t++;
    end
    sb.push_back(e);
  endtask

  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (an !== e.an) begin
          n_fail++;
          $display("FAIL an pos=%0d got=%b exp=%b", e.pos, an, e.an);
        end
        n_checks++;
        if (frame_start !== e.fs) begin
          n_fail++;
          $display("FAIL frame_start pos=%0d got=%b exp=%b", e.pos, frame_start, e.fs);
        end
        if (e.chk_seg) begin
          n_checks++;
          if (seg !== e.seg) begin
            n_fail++;
            $display("FAIL seg pos=%0d got=%h exp=%h", e.pos, seg, e.seg);
          end
        end
        n_checks++;
        if ($countones(~an) > 1) begin
          n_fail++;
          $display("FAIL glitch pos=%0d got an=%b exp at most one low", e.pos, an);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 6; i++) pat_in[i] = 8'h55 + 8'(i);
    @(negedge clk);
    for (int n = 0; n < 400; n++) begin
      rst = (n < 5) || (n == 330);
      if (n == 5) begin
        pat_in[0] = 8'h02; pat_in[1] = 8'h9E; pat_in[2] = 8'h24;
        pat_in[3] = 8'h0C; pat_in[4] = 8'h98; pat_in[5] = 8'h8F;
        brightness = 4'd15;
        blink_mask = 6'd0;
      end
      if (n == 5 + 27)  pat_in[0] = 8'h8F;
      if (n == 5 + 60)  blink_mask = 6'b000011;
      if (n == 5 + 170) brightness = 4'd5;
      if (n == 5 + 220) brightness = 4'd0;
      if (n == 5 + 270) brightness = 4'd15;
      push_expect();
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
